// File: rtl/rms_pkg.sv
// Shared types and width helpers for the RMS datapath.
package rms_pkg;

   typedef enum logic [0:0] {ST_ACC, ST_LAST} rms_state_e;

   function automatic int sq_w(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int acc_w(input int data_w, input int log2_n);
      return 2 * data_w + log2_n;
   endfunction

endpackage

// File: rtl/rms_mean_square_acc_if.sv
// Sample input and mean-square result handshake of the accumulator.
interface rms_mean_square_acc_if
   import rms_pkg::*;
#(
   parameter int DATA_W = 8
);
   logic                      in_valid;
   logic [DATA_W-1:0]         in_data;
   logic                      mean_valid;
   logic                      mean_ready;
   logic [sq_w(DATA_W)-1:0]   mean_sq;
   logic                      overrun;

   modport master (output in_valid, in_data, mean_ready,
                   input  mean_valid, mean_sq, overrun);
   modport slave  (input  in_valid, in_data, mean_ready,
                   output mean_valid, mean_sq, overrun);
endinterface

// File: rtl/rms_square_stage.sv
// Registered squarer: zero- or sign-extends the sample and squares it in one stage.
module rms_square_stage
   import rms_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TC_MODE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    sq_vld,
   output logic [sq_w(DATA_W)-1:0] sq_reg
);
   localparam int SQ_W = sq_w(DATA_W);

   logic [SQ_W-1:0] ext;
   logic [SQ_W-1:0] sq_reg_d, sq_reg_q;
   logic            sq_vld_d, sq_vld_q;

   // The low 2*DATA_W bits of the extended product are exact, since any square fits.
   always_comb begin
      if (TC_MODE != 0) ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
      else              ext = {{DATA_W{1'b0}}, in_data};
      sq_reg_d = in_valid ? ext * ext : sq_reg_q;
      sq_vld_d = in_valid & ~clr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sq_reg_q <= '0;
         sq_vld_q <= 1'b0;
      end else begin
         sq_reg_q <= sq_reg_d;
         sq_vld_q <= sq_vld_d;
      end
   end

   assign sq_reg = sq_reg_q;
   assign sq_vld = sq_vld_q;
endmodule

// File: rtl/rms_mean_square_acc.sv
// Block-windowed mean-square accumulator: sums 2**LOG2_N squared samples, holds the mean.
// Define RMS_ACC_ROUND_EN for round-half-up instead of truncation.
module rms_mean_square_acc
   import rms_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int LOG2_N  = 2,
   parameter int TC_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   rms_mean_square_acc_if.slave      bus
);
   localparam int SQ_W  = sq_w(DATA_W);
   localparam int ACC_W = acc_w(DATA_W, LOG2_N);

   localparam logic [0:0]        S_ACC    = ST_ACC;
   localparam logic [0:0]        S_LAST   = ST_LAST;
   localparam logic [LOG2_N-1:0] CNT_LAST = '1;
   localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);
`ifdef RMS_ACC_ROUND_EN
   localparam logic [ACC_W-1:0]  RND = {{(ACC_W-1){1'b0}}, 1'b1} << (LOG2_N-1);
`else
   localparam logic [ACC_W-1:0]  RND = '0;
`endif

   logic              sq_vld;
   logic [SQ_W-1:0]   sq_reg;

   logic [0:0]        state_d, state_q;
   logic [ACC_W-1:0]  acc_d, acc_q;
   logic [LOG2_N-1:0] cnt_d, cnt_q;
   logic              mean_valid_d, mean_valid_q;
   logic [SQ_W-1:0]   mean_sq_d, mean_sq_q;
   logic              overrun_d, overrun_q;
   logic [ACC_W-1:0]  rnd_sum;
   logic [ACC_W-1:0]  sq_ext;

   rms_square_stage #(
      .DATA_W  (DATA_W),
      .TC_MODE (TC_MODE)
   ) u_square (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (bus.in_valid),
      .in_data  (bus.in_data),
      .sq_vld   (sq_vld),
      .sq_reg   (sq_reg)
   );

   assign sq_ext  = {{LOG2_N{1'b0}}, sq_reg};
   assign rnd_sum = acc_q + RND;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      mean_valid_d = mean_valid_q;
      mean_sq_d    = mean_sq_q;
      overrun_d    = overrun_q;

      if (mean_valid_q && bus.mean_ready) mean_valid_d = 1'b0;

      if (clr) begin
         acc_d   = '0;
         cnt_d   = '0;
         state_d = S_ACC;
      end else if (state_q == S_LAST) begin
         mean_sq_d    = rnd_sum[LOG2_N +: SQ_W];
         mean_valid_d = 1'b1;
         if (mean_valid_q && !bus.mean_ready) overrun_d = 1'b1;
         // A sample landing here opens the next window so nothing is lost.
         acc_d   = sq_vld ? sq_ext  : '0;
         cnt_d   = sq_vld ? CNT_ONE : '0;
         state_d = S_ACC;
      end else if (sq_vld) begin
         acc_d = acc_q + sq_ext;
         cnt_d = cnt_q + CNT_ONE;
         if (cnt_q == CNT_LAST) state_d = S_LAST;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_ACC;
         acc_q        <= '0;
         cnt_q        <= '0;
         mean_valid_q <= 1'b0;
         mean_sq_q    <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         mean_valid_q <= mean_valid_d;
         mean_sq_q    <= mean_sq_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.mean_valid = mean_valid_q;
   assign bus.mean_sq    = mean_sq_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_rms_mean_square_acc.sv
// Directed bench: one unsigned and one two's-complement instance, DATA_W=8, LOG2_N=2.
module tb_rms_mean_square_acc;
   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rms_mean_square_acc_if #(.DATA_W(8)) b0 ();
   rms_mean_square_acc_if #(.DATA_W(8)) b1 ();

   rms_mean_square_acc #(.DATA_W(8), .LOG2_N(2), .TC_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b0.slave));
   rms_mean_square_acc #(.DATA_W(8), .LOG2_N(2), .TC_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b1.slave));

   typedef struct packed {
      logic            tc;
      logic [3:0][7:0] s;
      logic [15:0]     exp_t;
      logic [15:0]     exp_r;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic tc, input logic v, input logic [7:0] d);
      b0.in_valid = tc ? 1'b0 : v;
      b1.in_valid = tc ? v : 1'b0;
      b0.in_data  = d;
      b1.in_data  = d;
   endtask

   function automatic logic get_mv(input logic tc);
      return tc ? b1.mean_valid : b0.mean_valid;
   endfunction
   function automatic logic [15:0] get_ms(input logic tc);
      return tc ? b1.mean_sq : b0.mean_sq;
   endfunction
   function automatic logic get_ov(input logic tc);
      return tc ? b1.overrun : b0.overrun;
   endfunction

   function automatic logic [15:0] pick(input logic [15:0] t, input logic [15:0] r);
`ifdef RMS_ACC_ROUND_EN
      return r;
`else
      return t;
`endif
   endfunction

   // Four back-to-back samples; returns after the edge that samples the last one.
   task automatic send4(input logic tc, input logic [3:0][7:0] s);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         drive(tc, 1'b1, s[j]);
      end
      @(posedge clk); #1;
      drive(tc, 1'b0, 8'd0);
   endtask

   int          res_cyc [$];
   logic [15:0] res_val [$];

   initial begin
      vecs[0] = '{1'b1, {8'd6,   8'hFB, 8'd4,   8'd3  }, 16'd21,    16'd22   };
      vecs[1] = '{1'b1, {8'h80,  8'h80, 8'h80,  8'h80 }, 16'd16384, 16'd16384};
      vecs[2] = '{1'b0, {8'd255, 8'd255,8'd255, 8'd255}, 16'd65025, 16'd65025};
      vecs[3] = '{1'b0, {8'd0,   8'd0,  8'd0,   8'd0  }, 16'd0,     16'd0    };
      vecs[4] = '{1'b0, {8'd4,   8'd3,  8'd2,   8'd1  }, 16'd7,     16'd8    };
      vecs[5] = '{1'b1, {8'hFF,  8'hFF, 8'hFF,  8'hFF }, 16'd1,     16'd1    };
      vecs[6] = '{1'b0, {8'd0,   8'd0,  8'd1,   8'd1  }, 16'd0,     16'd1    };
      vecs[7] = '{1'b1, {8'd0,   8'd0,  8'd0,   8'hFE }, 16'd1,     16'd1    };

      rst_n = 1'b0;
      clr   = 1'b0;
      drive(1'b0, 1'b0, 8'd0);
      b0.mean_ready = 1'b1;
      b1.mean_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int t = 0; t < 2; t++) begin
         chk("reset_mean_valid", 32'(get_mv(t[0])), 32'd0);
         chk("reset_mean_sq",    32'(get_ms(t[0])), 32'd0);
         chk("reset_overrun",    32'(get_ov(t[0])), 32'd0);
      end

      // Table: one window each, latency and single-cycle valid with ready held high.
      for (int i = 0; i < 8; i++) begin
         send4(vecs[i].tc, vecs[i].s);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_not_early", i), 32'(get_mv(vecs[i].tc)), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), 32'(get_mv(vecs[i].tc)), 32'd1);
         chk($sformatf("vec%0d_mean_sq", i), 32'(get_ms(vecs[i].tc)),
             32'(pick(vecs[i].exp_t, vecs[i].exp_r)));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_one_cycle", i), 32'(get_mv(vecs[i].tc)), 32'd0);
      end

      // Held result, then overwritten by an unaccepted second window.
      b1.mean_ready = 1'b0;
      send4(1'b1, {8'd1, 8'd1, 8'd1, 8'd1});
      repeat (2) @(posedge clk); #1;
      chk("hold_first_valid",   32'(b1.mean_valid), 32'd1);
      chk("hold_first_value",   32'(b1.mean_sq),    32'd1);
      chk("hold_first_overrun", 32'(b1.overrun),    32'd0);
      repeat (5) @(posedge clk); #1;
      chk("hold_stable_value",  32'(b1.mean_sq),    32'd1);
      chk("hold_stable_valid",  32'(b1.mean_valid), 32'd1);
      send4(1'b1, {8'd2, 8'd2, 8'd2, 8'd2});
      @(posedge clk); #1;
      chk("overwrite_pending_value", 32'(b1.mean_sq), 32'd1);
      @(posedge clk); #1;
      chk("overwrite_value",   32'(b1.mean_sq),    32'd4);
      chk("overwrite_overrun", 32'(b1.overrun),    32'd1);
      b1.mean_ready = 1'b1;
      @(posedge clk); #1;
      chk("accept_drops_valid", 32'(b1.mean_valid), 32'd0);
      chk("overrun_sticky",     32'(b1.overrun),    32'd1);

      // Reset while a result is held and a partial window is in flight.
      b1.mean_ready = 1'b0;
      send4(1'b1, {8'd3, 8'd3, 8'd3, 8'd3});
      repeat (2) @(posedge clk); #1;
      chk("pre_reset_value", 32'(b1.mean_sq), 32'd9);
      @(posedge clk); #1; drive(1'b1, 1'b1, 8'd7);
      @(posedge clk); #1; drive(1'b1, 1'b1, 8'd7);
      @(posedge clk); #1; drive(1'b1, 1'b0, 8'd0);
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      chk("midreset_valid",   32'(b1.mean_valid), 32'd0);
      chk("midreset_mean_sq", 32'(b1.mean_sq),    32'd0);
      chk("midreset_overrun", 32'(b1.overrun),    32'd0);
      b1.mean_ready = 1'b1;
      send4(1'b1, {8'd1, 8'd1, 8'd1, 8'd1});
      repeat (2) @(posedge clk); #1;
      chk("post_reset_valid", 32'(b1.mean_valid), 32'd1);
      chk("post_reset_value", 32'(b1.mean_sq),    32'd1);

      // Continuous stream of 12 samples crossing two LAST boundaries.
      res_cyc.delete();
      res_val.delete();
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         if (b0.mean_valid) begin
            res_cyc.push_back(c);
            res_val.push_back(b0.mean_sq);
         end
         if (c < 12) drive(1'b0, 1'b1, 8'(c + 1));
         else        drive(1'b0, 1'b0, 8'd0);
      end
      chk("stream_count", 32'(res_cyc.size()), 32'd3);
      if (res_cyc.size() == 3) begin
         chk("stream_cyc0", 32'(res_cyc[0]), 32'd6);
         chk("stream_cyc1", 32'(res_cyc[1]), 32'd10);
         chk("stream_cyc2", 32'(res_cyc[2]), 32'd14);
         chk("stream_val0", 32'(res_val[0]), 32'(pick(16'd7,   16'd8)));
         chk("stream_val1", 32'(res_val[1]), 32'(pick(16'd43,  16'd44)));
         chk("stream_val2", 32'(res_val[2]), 32'(pick(16'd111, 16'd112)));
      end

      // clr discards a partial window and the sample presented alongside it.
      @(posedge clk); #1; drive(1'b0, 1'b1, 8'd5);
      @(posedge clk); #1; drive(1'b0, 1'b1, 8'd5);
      @(posedge clk); #1; drive(1'b0, 1'b1, 8'd9); clr = 1'b1;
      @(posedge clk); #1; drive(1'b0, 1'b0, 8'd0); clr = 1'b0;
      res_val.delete();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (b0.mean_valid) res_val.push_back(b0.mean_sq);
         if (c < 4) drive(1'b0, 1'b1, 8'd2);
         else       drive(1'b0, 1'b0, 8'd0);
      end
      chk("clr_result_count", 32'(res_val.size()), 32'd1);
      if (res_val.size() >= 1) chk("clr_result_value", 32'(res_val[0]), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
